// File: rtl/voice_scheduler.sv
// voice_scheduler: allocates note-on/off events to square-wave voice slots
// (free slot first, otherwise steal the oldest), runs one half-period timer
// per slot, and on each sample request walks the slots one per cycle to sum
// the active voices into a signed 32-bit sample.
//
// Handshake: an event transfers on a rising CLOCK_50 edge where ev_valid and
// ev_ready are both high; ev_valid, ev_key_on and ev_period must be held
// stable until that edge. mix_req has no ready: it is taken in IDLE or kept
// in a single pending flag, and extra requests while pending are dropped.
module voice_scheduler #(
  parameter int          NUM_VOICES = 4,
  parameter int          PER_W      = 20,
  parameter logic [31:0] AMPLITUDE  = 32'd10000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_key_on,
  input  logic [PER_W-1:0]      ev_period,
  input  logic                  mix_req,
  output logic                  mix_valid,
  output logic [31:0]           mix_sample,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  steal,
  output logic [1:0]            dbg_state
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [IDX_W-1:0] AGE_MAX  = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVENT = 2'd1,
    S_MIX   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic                  alive_q, alive_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [31:0]           acc_q, acc_d;
  logic                  done_q, done_d;
  logic                  mix_valid_q, mix_valid_d;
  logic [31:0]           mix_sample_q, mix_sample_d;
  logic                  steal_q, steal_d;
  logic                  key_q, key_d;
  logic [PER_W-1:0]      per_q, per_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0] phase_q, phase_d;
  logic [PER_W-1:0]      period_q [NUM_VOICES];
  logic [PER_W-1:0]      period_d [NUM_VOICES];
  logic [PER_W-1:0]      cnt_q [NUM_VOICES];
  logic [PER_W-1:0]      cnt_d [NUM_VOICES];
  logic [IDX_W-1:0]      age_q [NUM_VOICES];
  logic [IDX_W-1:0]      age_d [NUM_VOICES];

  logic                  hit, free_found;
  logic [IDX_W-1:0]      hit_idx, free_idx, old_idx, old_age, load_idx;
  logic [31:0]           contrib;

  assign mix_valid    = mix_valid_q;
  assign mix_sample   = mix_sample_q;
  assign voice_active = active_q;
  assign steal        = steal_q;
  assign dbg_state    = state_q;

  // Slot search for the latched event: matching period, lowest free, oldest.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = age_q[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!hit && active_q[i] && (period_q[i] == per_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!free_found && !active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      // strict compare keeps the lowest index on equal ages
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IDX_W'(i);
      end
    end
  end

  // Next-state: control FSM, voice timers, allocation and serial mix.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    alive_d      = 1'b1;
    idx_d        = idx_q;
    acc_d        = acc_q;
    done_d       = 1'b0;
    mix_valid_d  = done_q;
    mix_sample_d = done_q ? acc_q : mix_sample_q;
    steal_d      = 1'b0;
    key_d        = key_q;
    per_d        = per_q;
    ev_ready     = 1'b0;
    load_idx     = '0;
    contrib      = '0;
    active_d     = active_q;
    phase_d      = phase_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      period_d[i] = period_q[i];
      age_d[i]    = age_q[i];
      if (active_q[i]) begin
        if (cnt_q[i] == period_q[i]) begin
          cnt_d[i]   = '0;
          phase_d[i] = ~phase_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + PER_W'(1);
        end
      end else begin
        cnt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (mix_req || pend_q) begin
          state_d = S_MIX;
          pend_d  = 1'b0;
          acc_d   = '0;
          idx_d   = '0;
        end else begin
          ev_ready = alive_q;
          if (ev_valid && alive_q) begin
            key_d   = ev_key_on;
            per_d   = ev_period;
            state_d = S_EVENT;
          end
        end
      end
      S_EVENT: begin
        if (mix_req) pend_d = 1'b1;
        state_d = S_IDLE;
        if (key_q) begin
          if (per_q != '0) begin
            load_idx = hit ? hit_idx : (free_found ? free_idx : old_idx);
            steal_d  = !hit && !free_found;
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == load_idx) begin
                active_d[i] = 1'b1;
                period_d[i] = per_q;
                cnt_d[i]    = '0;
                phase_d[i]  = 1'b1;
                age_d[i]    = '0;
              end else if (active_q[i]) begin
                age_d[i] = (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + IDX_W'(1);
              end
            end
          end
        end else begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && (period_q[i] == per_q)) begin
              active_d[i] = 1'b0;
              phase_d[i]  = 1'b0;
              cnt_d[i]    = '0;
              age_d[i]    = '0;
            end
          end
        end
      end
      S_MIX: begin
        if (mix_req) pend_d = 1'b1;
        if (active_q[idx_q]) begin
          contrib = phase_q[idx_q] ? AMPLITUDE : (32'd0 - AMPLITUDE);
        end
        acc_d = acc_q + contrib;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      alive_q      <= 1'b0;
      idx_q        <= '0;
      acc_q        <= '0;
      done_q       <= 1'b0;
      mix_valid_q  <= 1'b0;
      mix_sample_q <= '0;
      steal_q      <= 1'b0;
      key_q        <= 1'b0;
      per_q        <= '0;
      active_q     <= '0;
      phase_q      <= '0;
      period_q     <= '{default: '0};
      cnt_q        <= '{default: '0};
      age_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      alive_q      <= alive_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      done_q       <= done_d;
      mix_valid_q  <= mix_valid_d;
      mix_sample_q <= mix_sample_d;
      steal_q      <= steal_d;
      key_q        <= key_d;
      per_q        <= per_d;
      active_q     <= active_d;
      phase_q      <= phase_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      age_q        <= age_d;
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: a table of note events with the
// expected slot pattern, steal pulse and mixed sample, plus hand-written
// sequences for phase timing, mix/event collision and reset during a mix.
module tb_voice_scheduler;
  localparam int          NV    = 4;
  localparam int          PW    = 20;
  localparam logic [31:0] AMP   = 32'd10000000;
  localparam logic [31:0] AMP_N = 32'hFF676980;   // -10000000

  logic          clk;
  logic          rst_n;
  logic          ev_valid;
  logic          ev_ready;
  logic          ev_key_on;
  logic [PW-1:0] ev_period;
  logic          mix_req;
  logic          mix_valid;
  logic [31:0]   mix_sample;
  logic [NV-1:0] voice_active;
  logic          steal;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          key;
    logic [PW-1:0] per;
    logic [NV-1:0] exp_active;
    logic          exp_steal;
    logic [31:0]   exp_sample;
  } vec_t;

  vec_t vecs [18];

  voice_scheduler #(
    .NUM_VOICES(NV),
    .PER_W     (PW),
    .AMPLITUDE (AMP)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (rst_n),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_key_on   (ev_key_on),
    .ev_period   (ev_period),
    .mix_req     (mix_req),
    .mix_valid   (mix_valid),
    .mix_sample  (mix_sample),
    .voice_active(voice_active),
    .steal       (steal),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ev_valid  = 1'b0;
    ev_key_on = 1'b0;
    ev_period = '0;
    mix_req   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // driver: present an event and return just after its handshake edge
  task automatic send_event(input logic key, input logic [PW-1:0] per);
    int w;
    w         = 0;
    ev_valid  = 1'b1;
    ev_key_on = key;
    ev_period = per;
    while (ev_ready !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    check("ev_ready_wait", ev_ready, 1);
    step();
    ev_valid = 1'b0;
  endtask

  // driver: one-cycle mix request, wait (bounded) for mix_valid
  task automatic run_mix(output logic [31:0] sample, output int lat);
    mix_req = 1'b1;
    step();
    mix_req = 1'b0;
    lat = 0;
    while (mix_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    sample = mix_sample;
  endtask

  initial begin
    logic [31:0] smp;
    int          lat;
    int          hs_e;
    int          mv_n;
    int          mv_e1;
    int          mv_e2;
    bit          blocked_bad;
    bit          saw_mv;

    // key, period, expected active, expected steal, expected sample
    vecs[0]  = '{1'b1, 20'd1000, 4'b0001, 1'b0, 32'd10000000};
    vecs[1]  = '{1'b1, 20'd1000, 4'b0001, 1'b0, 32'd10000000};
    vecs[2]  = '{1'b1, 20'd2000, 4'b0011, 1'b0, 32'd20000000};
    vecs[3]  = '{1'b1, 20'd0,    4'b0011, 1'b0, 32'd20000000};
    vecs[4]  = '{1'b1, 20'd3000, 4'b0111, 1'b0, 32'd30000000};
    vecs[5]  = '{1'b0, 20'd9999, 4'b0111, 1'b0, 32'd30000000};
    vecs[6]  = '{1'b1, 20'd4000, 4'b1111, 1'b0, 32'd40000000};
    vecs[7]  = '{1'b1, 20'd5000, 4'b1111, 1'b1, 32'd40000000};
    vecs[8]  = '{1'b0, 20'd2000, 4'b1101, 1'b0, 32'd30000000};
    vecs[9]  = '{1'b1, 20'd6000, 4'b1111, 1'b0, 32'd40000000};
    vecs[10] = '{1'b1, 20'd7000, 4'b1111, 1'b1, 32'd40000000};
    vecs[11] = '{1'b0, 20'd5000, 4'b1110, 1'b0, 32'd30000000};
    vecs[12] = '{1'b1, 20'd8000, 4'b1111, 1'b0, 32'd40000000};
    vecs[13] = '{1'b1, 20'd9000, 4'b1111, 1'b1, 32'd40000000};
    vecs[14] = '{1'b0, 20'd8000, 4'b1110, 1'b0, 32'd30000000};
    vecs[15] = '{1'b0, 20'd9000, 4'b0110, 1'b0, 32'd20000000};
    vecs[16] = '{1'b0, 20'd6000, 4'b0100, 1'b0, 32'd10000000};
    vecs[17] = '{1'b1, 20'd7000, 4'b0100, 1'b0, 32'd10000000};

    // reset state
    rst_n     = 1'b1;
    ev_valid  = 1'b0;
    ev_key_on = 1'b0;
    ev_period = '0;
    mix_req   = 1'b0;
    #2;
    rst_n = 1'b0;
    repeat (2) step();
    check("rst_mix_valid",    mix_valid,    0);
    check("rst_mix_sample",   mix_sample,   0);
    check("rst_voice_active", voice_active, 0);
    check("rst_steal",        steal,        0);
    check("rst_ev_ready",     ev_ready,     0);
    check("rst_state",        dbg_state,    0);
    rst_n = 1'b1;
    step();
    check("idle_ev_ready", ev_ready, 1);

    // empty mix: latency 5, sample 0
    run_mix(smp, lat);
    check("empty_mix_latency", lat, 5);
    check("empty_mix_sample",  smp, 0);
    step();
    check("mix_valid_one_cycle", mix_valid, 0);

    // table-driven allocation vectors
    for (int i = 0; i < 18; i++) begin
      send_event(vecs[i].key, vecs[i].per);
      step();
      check($sformatf("vec%0d_active", i), voice_active, vecs[i].exp_active);
      check($sformatf("vec%0d_steal", i),  steal,        vecs[i].exp_steal);
      step();
      check($sformatf("vec%0d_steal_drop", i), steal, 0);
      run_mix(smp, lat);
      check($sformatf("vec%0d_mix_latency", i), lat, 5);
      check($sformatf("vec%0d_mix_sample", i),  smp, vecs[i].exp_sample);
    end

    // phase timing on period 100: toggle after 101 cycles, retrigger restarts
    do_reset();
    send_event(1'b1, 20'd100);
    step();
    check("p100_active", voice_active, 4'b0001);
    repeat (99) step();
    run_mix(smp, lat);
    check("p100_last_high_sample", smp, AMP);
    run_mix(smp, lat);
    check("p100_low_sample", smp, AMP_N);
    send_event(1'b1, 20'd100);
    step();
    check("retrig_active", voice_active, 4'b0001);
    check("retrig_steal",  steal,        0);
    repeat (100) step();
    run_mix(smp, lat);
    check("retrig_first_low_sample", smp, AMP_N);

    // mix and event in the same IDLE cycle, second request pended, third dropped
    do_reset();
    ev_valid  = 1'b1;
    ev_key_on = 1'b1;
    ev_period = 20'd1000;
    mix_req   = 1'b1;
    #1;
    check("collide_ev_ready", ev_ready, 0);
    step();
    mix_req     = 1'b0;
    hs_e        = 0;
    mv_n        = 0;
    mv_e1       = 0;
    mv_e2       = 0;
    blocked_bad = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      mix_req = (e == 2 || e == 4);
      #1;
      if (e <= 9 && ev_ready !== 1'b0) blocked_bad = 1'b1;
      if (hs_e == 0 && ev_valid && ev_ready) hs_e = e;
      step();
      if (hs_e == e) ev_valid = 1'b0;
      if (mix_valid === 1'b1) begin
        mv_n++;
        check("collide_mix_sample", mix_sample, 0);
        if (mv_n == 1) mv_e1 = e;
        if (mv_n == 2) mv_e2 = e;
      end
    end
    mix_req  = 1'b0;
    ev_valid = 1'b0;
    check("collide_ev_blocked",  blocked_bad, 0);
    check("collide_first_mix",   mv_e1, 5);
    check("collide_second_mix",  mv_e2, 10);
    check("collide_mix_count",   mv_n,  2);
    check("collide_ev_accept",   hs_e,  10);
    check("collide_ev_applied",  voice_active, 4'b0001);

    // reset during MIX clears everything and cancels the mix
    run_mix(smp, lat);
    check("pre_reset_sample", smp, AMP);
    mix_req = 1'b1;
    step();
    mix_req = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midmix_rst_mix_valid",    mix_valid,    0);
    check("midmix_rst_mix_sample",   mix_sample,   0);
    check("midmix_rst_voice_active", voice_active, 0);
    check("midmix_rst_steal",        steal,        0);
    check("midmix_rst_ev_ready",     ev_ready,     0);
    check("midmix_rst_state",        dbg_state,    0);
    repeat (2) step();
    rst_n  = 1'b1;
    saw_mv = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (mix_valid !== 1'b0) saw_mv = 1'b1;
    end
    check("midmix_no_mix_valid", saw_mv, 0);
    check("post_rst_active", voice_active, 0);
    run_mix(smp, lat);
    check("post_rst_mix_latency", lat, 5);
    check("post_rst_mix_sample",  smp, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
